// File: rtl/spike_collector.sv
// spike_collector: round-robin collects spike events from the clusters,
// buffers them in an event FIFO and replays them to the next layer.
// End of layer is flagged once every scheduler reported done and the
// buffer, the arbiter and the output stage are all idle.
module spike_collector #(
  parameter int CLUSTER_NUM = 4,
  parameter int POST_WIDTH  = 32,
  parameter int DEPTH       = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [CLUSTER_NUM-1:0]            post_req,
  input  logic [CLUSTER_NUM*POST_WIDTH-1:0] post_waddr,
  input  logic [CLUSTER_NUM*POST_WIDTH-1:0] post_wdata,
  output logic [CLUSTER_NUM-1:0]            post_grant,
  input  logic [CLUSTER_NUM-1:0]            finish_sche,
  input  logic                              pre_ready,
  output logic                              pre_grant,
  output logic [POST_WIDTH-1:0]             w_data,
  output logic [POST_WIDTH-1:0]             ev_addr,
  output logic [$clog2(DEPTH):0]            fifo_count,
  output logic [31:0]                       spike_cnt,
  output logic                              layer_done
);
  localparam int PtrW = $clog2(DEPTH);
  localparam int CntW = PtrW + 1;
  localparam int OccW = CntW + 1;
  localparam int RrW  = (CLUSTER_NUM > 1) ? $clog2(CLUSTER_NUM) : 1;
  localparam int SumW = RrW + 1;
  localparam int EntW = 2 * POST_WIDTH;
  localparam logic [SumW-1:0] NumClusters = SumW'(CLUSTER_NUM);
  localparam logic [OccW-1:0] DepthLimit  = OccW'(DEPTH);

  logic [CLUSTER_NUM-1:0] r_grant;
  logic [RrW-1:0]         r_rrPtr;
  logic [EntW-1:0]        r_mem [DEPTH];
  logic [PtrW-1:0]        r_wrPtr;
  logic [PtrW-1:0]        r_rdPtr;
  logic [CntW-1:0]        r_count;
  logic                   r_preGrant;
  logic [POST_WIDTH-1:0]  r_wData;
  logic [POST_WIDTH-1:0]  r_evAddr;
  logic [31:0]            r_spikeCnt;
  logic [CLUSTER_NUM-1:0] r_sticky;
  logic                   r_layerDone;

  logic [CLUSTER_NUM-1:0] w_eligible;
  logic [CLUSTER_NUM-1:0] w_nextGrant;
  logic [RrW-1:0]         w_nextRr;
  logic [SumW-1:0]        w_cand;
  logic [SumW-1:0]        w_after;
  logic [OccW-1:0]        w_occupancy;
  logic                   w_hasSpace;
  logic                   w_found;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_allDone;
  logic [EntW-1:0]        w_pushEntry;

  // Round-robin search from r_rrPtr; the cluster granted now is masked and room must remain for the push in flight
  always_comb begin
    w_eligible  = post_req & ~r_grant;
    w_occupancy = OccW'(r_count) + OccW'(|r_grant);
    w_hasSpace  = (w_occupancy < DepthLimit);
    w_nextGrant = '0;
    w_nextRr    = r_rrPtr;
    w_found     = 1'b0;
    w_cand      = '0;
    w_after     = '0;
    for (int k = 0; k < CLUSTER_NUM; k++) begin
      w_cand = SumW'(r_rrPtr) + SumW'(k);
      if (w_cand >= NumClusters) w_cand = w_cand - NumClusters;
      if (w_hasSpace && !w_found && w_eligible[w_cand[RrW-1:0]]) begin
        w_found = 1'b1;
        w_nextGrant[w_cand[RrW-1:0]] = 1'b1;
        w_after = w_cand + SumW'(1);
        if (w_after == NumClusters) w_after = '0;
        w_nextRr = w_after[RrW-1:0];
      end
    end
  end

  // Pick the address/data of the granted cluster; these are captured at the edge closing the grant cycle
  always_comb begin
    w_push      = |r_grant;
    w_pop       = (r_count != '0) && pre_ready;
    w_pushEntry = '0;
    for (int k = 0; k < CLUSTER_NUM; k++) begin
      if (r_grant[k]) begin
        w_pushEntry = {post_waddr[k*POST_WIDTH +: POST_WIDTH], post_wdata[k*POST_WIDTH +: POST_WIDTH]};
      end
    end
  end

  assign w_allDone = (&r_sticky) && (r_count == '0) && (post_req == '0) &&
                     (r_grant == '0) && !r_preGrant;

  // Register the one-hot grant and advance the round-robin pointer past the winner
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grant <= '0;
      r_rrPtr <= '0;
    end else begin
      r_grant <= w_nextGrant;
      r_rrPtr <= w_nextRr;
    end
  end

  // Event storage; stale contents are harmless because reset clears the pointers
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= w_pushEntry;
  end

  // FIFO bookkeeping and the output stage that replays the head entry downstream
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_preGrant <= 1'b0;
      r_wData    <= '0;
      r_evAddr   <= '0;
    end else begin
      r_preGrant <= w_pop;
      if (w_push) r_wrPtr <= r_wrPtr + PtrW'(1);
      if (w_pop) begin
        r_rdPtr  <= r_rdPtr + PtrW'(1);
        r_evAddr <= r_mem[r_rdPtr][EntW-1:POST_WIDTH];
        r_wData  <= r_mem[r_rdPtr][POST_WIDTH-1:0];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // End-of-layer detection; a finish pulse coinciding with the clear is kept for the next layer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sticky    <= '0;
      r_spikeCnt  <= '0;
      r_layerDone <= 1'b0;
    end else begin
      r_layerDone <= w_allDone;
      if (w_allDone) begin
        r_sticky   <= finish_sche;
        r_spikeCnt <= '0;
      end else begin
        r_sticky <= r_sticky | finish_sche;
        if (w_push && (r_spikeCnt != 32'hFFFF_FFFF)) r_spikeCnt <= r_spikeCnt + 32'd1;
      end
    end
  end

  assign post_grant = r_grant;
  assign pre_grant  = r_preGrant;
  assign w_data     = r_wData;
  assign ev_addr    = r_evAddr;
  assign fifo_count = r_count;
  assign spike_cnt  = r_spikeCnt;
  assign layer_done = r_layerDone;

endmodule

// File: tb/tb_spike_collector.sv
// tb_spike_collector: drives randomized cluster requesters against
// spike_collector and compares it with a queue-based event model.
module tb_spike_collector;
  localparam int N = 4;
  localparam int W = 32;
  localparam int D = 16;

  logic                 clk;
  logic                 rst;
  logic [N-1:0]         post_req;
  logic [N*W-1:0]       post_waddr;
  logic [N*W-1:0]       post_wdata;
  logic [N-1:0]         post_grant;
  logic [N-1:0]         finish_sche;
  logic                 pre_ready;
  logic                 pre_grant;
  logic [W-1:0]         w_data;
  logic [W-1:0]         ev_addr;
  logic [$clog2(D):0]   fifo_count;
  logic [31:0]          spike_cnt;
  logic                 layer_done;

  spike_collector #(.CLUSTER_NUM(N), .POST_WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .post_req(post_req), .post_waddr(post_waddr),
    .post_wdata(post_wdata), .post_grant(post_grant), .finish_sche(finish_sche),
    .pre_ready(pre_ready), .pre_grant(pre_grant), .w_data(w_data), .ev_addr(ev_addr),
    .fifo_count(fifo_count), .spike_cnt(spike_cnt), .layer_done(layer_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nCompared = 0;
  int nMismatched = 0;

  // requester agents and stimulus knobs
  logic [N-1:0] reqActive;
  logic [W-1:0] reqAddr [N];
  logic [W-1:0] reqData [N];
  int           reqProb;
  int           readyProb;
  int           reqBudget;
  logic         preReadyVar;
  logic [N-1:0] finVec;

  // reference model state
  logic [2*W-1:0] q[$];
  logic [N-1:0]   mGrant;
  int             rrPtr;
  logic           mPreGrant;
  logic           mLayerDone;
  logic [W-1:0]   mAddr;
  logic [W-1:0]   mData;
  logic [31:0]    mSpike;
  logic [N-1:0]   sticky;

  task automatic driveInputs();
    post_req = reqActive;
    for (int i = 0; i < N; i++) begin
      post_waddr[i*W +: W] = reqAddr[i];
      post_wdata[i*W +: W] = reqData[i];
    end
    pre_ready   = preReadyVar;
    finish_sche = finVec;
  endtask

  task automatic modelReset();
    q.delete();
    mGrant = '0; rrPtr = 0; mPreGrant = 1'b0; mLayerDone = 1'b0;
    mAddr = '0; mData = '0; mSpike = '0; sticky = '0;
  endtask

  task automatic applyReset();
    rst = 1'b0;
    reqActive = '0; finVec = '0; preReadyVar = 1'b0;
    reqBudget = 0; reqProb = 0; readyProb = 0;
    for (int i = 0; i < N; i++) begin reqAddr[i] = '0; reqData[i] = '0; end
    driveInputs();
    modelReset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  // one clock: predict from the rules, advance, then let the requesters react
  task automatic stepCycle();
    logic [N-1:0] elig, ng, oldGrant;
    int occ, start, c;
    bit pop, cond;
    occ  = q.size();
    elig = reqActive & ~mGrant;
    ng   = '0;
    if (occ + ((mGrant != '0) ? 1 : 0) < D) begin
      start = rrPtr;
      for (int k = 0; k < N; k++) begin
        c = (start + k) % N;
        if (ng == '0 && elig[c]) begin ng[c] = 1'b1; rrPtr = (c + 1) % N; end
      end
    end
    pop  = preReadyVar && (occ > 0);
    cond = (&sticky) && (occ == 0) && (reqActive == '0) && (mGrant == '0) && !mPreGrant;
    @(posedge clk);
    if (pop) {mAddr, mData} = q.pop_front();
    if (mGrant != '0) begin
      for (int i = 0; i < N; i++) if (mGrant[i]) q.push_back({reqAddr[i], reqData[i]});
      if (mSpike != 32'hFFFF_FFFF) mSpike = mSpike + 1;
    end
    if (cond) begin sticky = finVec; mSpike = '0; end
    else sticky = sticky | finVec;
    oldGrant = mGrant; mGrant = ng; mPreGrant = pop; mLayerDone = cond;
    #1;
    finVec = '0;
    for (int i = 0; i < N; i++) if (oldGrant[i]) reqActive[i] = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!reqActive[i] && reqBudget != 0 && int'($urandom_range(99)) < reqProb) begin
        reqActive[i] = 1'b1; reqAddr[i] = $urandom; reqData[i] = $urandom;
        if (reqBudget > 0) reqBudget--;
      end
    end
    preReadyVar = (int'($urandom_range(99)) < readyProb);
    driveInputs();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    reqActive = '0; finVec = '0; preReadyVar = 1'b0;
    for (int i = 0; i < N; i++) begin reqAddr[i] = '0; reqData[i] = '0; end
    driveInputs();
    #3;
    nCompared++;
    if ({post_grant, pre_grant, w_data, ev_addr, fifo_count, spike_cnt, layer_done} !== '0) begin
      nMismatched++; $display("[TB] FAIL reset_outputs: got grant=%b pg=%b wd=%h ea=%h cnt=%0d sc=%0d ld=%b want all 0",
        post_grant, pre_grant, w_data, ev_addr, fifo_count, spike_cnt, layer_done);
    end
    applyReset();
    for (int t = 0; t < 3; t++) begin
      stepCycle();
      nCompared++;
      if ({post_grant, pre_grant, fifo_count, spike_cnt, layer_done} !== '0) begin
        nMismatched++; $display("[TB] FAIL reset_idle: got grant=%b pg=%b cnt=%0d sc=%0d ld=%b want all 0",
          post_grant, pre_grant, fifo_count, spike_cnt, layer_done);
      end
    end
  endtask

  task automatic test_single();
    readyProb = 100; reqProb = 0; reqBudget = 0;
    reqActive[2] = 1'b1; reqAddr[2] = 32'h10; reqData[2] = 32'h5; preReadyVar = 1'b1;
    driveInputs();
    stepCycle();
    nCompared++;
    if (post_grant !== 4'b0100) begin nMismatched++; $display("[TB] FAIL single_grant: got %b want 0100", post_grant); end
    stepCycle();
    nCompared++;
    if (post_grant !== 4'b0000 || pre_grant !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL single_gap: got grant=%b pg=%b want 0000/0", post_grant, pre_grant);
    end
    stepCycle();
    nCompared++;
    if (pre_grant !== 1'b1 || ev_addr !== 32'h10 || w_data !== 32'h5) begin
      nMismatched++; $display("[TB] FAIL single_event: got pg=%b addr=%h data=%h want 1/10/5", pre_grant, ev_addr, w_data);
    end
    nCompared++;
    if (spike_cnt !== 32'd1) begin nMismatched++; $display("[TB] FAIL single_spike_cnt: got %0d want 1", spike_cnt); end
    repeat (3) stepCycle();
  endtask

  task automatic test_fairness();
    int cnt [N];
    int expIdx, g, total, mx, mn;
    applyReset();
    for (int i = 0; i < N; i++) cnt[i] = 0;
    reqProb = 100; reqBudget = -1; readyProb = 100;
    stepCycle();
    expIdx = 0; total = 0;
    for (int t = 0; t < 40; t++) begin
      stepCycle();
      nCompared++;
      if (post_grant !== mGrant) begin nMismatched++; $display("[TB] FAIL fair_grant t=%0d: got %b want %b", t, post_grant, mGrant); end
      if (post_grant != '0) begin
        g = -1;
        for (int i = N - 1; i >= 0; i--) if (post_grant[i]) g = i;
        nCompared++;
        if (g != expIdx || $countones(post_grant) != 1) begin
          nMismatched++; $display("[TB] FAIL fair_order t=%0d: got %b want cluster %0d", t, post_grant, expIdx);
        end
        if (g >= 0) cnt[g]++;
        expIdx = (expIdx + 1) % N; total++;
      end
    end
    mx = cnt[0]; mn = cnt[0];
    for (int i = 1; i < N; i++) begin if (cnt[i] > mx) mx = cnt[i]; if (cnt[i] < mn) mn = cnt[i]; end
    nCompared++;
    if (mx - mn > 1 || total < 36) begin
      nMismatched++; $display("[TB] FAIL fair_balance: got min=%0d max=%0d total=%0d want spread<=1 total>=36", mn, mx, total);
    end
    reqProb = 0;
    repeat (12) stepCycle();
  endtask

  task automatic test_full();
    int grants;
    readyProb = 0; preReadyVar = 1'b0; reqProb = 100; reqBudget = -1;
    driveInputs();
    grants = 0;
    for (int t = 0; t < 40; t++) begin
      stepCycle();
      if (post_grant != '0) grants++;
      nCompared++;
      if (post_grant !== mGrant) begin nMismatched++; $display("[TB] FAIL full_grant t=%0d: got %b want %b", t, post_grant, mGrant); end
    end
    nCompared++;
    if (grants != 16 || fifo_count !== 5'd16) begin
      nMismatched++; $display("[TB] FAIL full_stop: got grants=%0d cnt=%0d want 16/16", grants, fifo_count);
    end
    preReadyVar = 1'b1;
    driveInputs();
    grants = 0;
    for (int t = 0; t < 10; t++) begin
      stepCycle();
      if (post_grant != '0) grants++;
      nCompared++;
      if (pre_grant !== mPreGrant) begin nMismatched++; $display("[TB] FAIL full_pop t=%0d: got %b want %b", t, pre_grant, mPreGrant); end
    end
    nCompared++;
    if (grants != 1 || fifo_count !== 5'd16) begin
      nMismatched++; $display("[TB] FAIL full_one_more: got grants=%0d cnt=%0d want 1/16", grants, fifo_count);
    end
    reqProb = 0; readyProb = 100;
    for (int t = 0; t < 30; t++) begin
      stepCycle();
      nCompared++;
      if (pre_grant !== mPreGrant || ev_addr !== mAddr || w_data !== mData) begin
        nMismatched++; $display("[TB] FAIL full_drain t=%0d: got pg=%b %h/%h want %b %h/%h", t, pre_grant, ev_addr, w_data, mPreGrant, mAddr, mData);
      end
    end
    nCompared++;
    if (fifo_count !== 5'd0) begin nMismatched++; $display("[TB] FAIL full_empty: got %0d want 0", fifo_count); end
  endtask

  task automatic test_back_to_back();
    reqProb = 100; reqBudget = 8; readyProb = 0;
    repeat (14) stepCycle();
    nCompared++;
    if (fifo_count !== 5'd8) begin nMismatched++; $display("[TB] FAIL b2b_fill: got %0d want 8", fifo_count); end
    reqBudget = 40;
    stepCycle();
    readyProb = 100;
    stepCycle();
    stepCycle();
    for (int t = 0; t < 16; t++) begin
      nCompared++;
      if (fifo_count !== 5'd8 || post_grant == '0) begin
        nMismatched++; $display("[TB] FAIL b2b_level t=%0d: got cnt=%0d grant=%b want 8 with a grant", t, fifo_count, post_grant);
      end
      nCompared++;
      if (pre_grant !== 1'b1 || ev_addr !== mAddr || w_data !== mData) begin
        nMismatched++; $display("[TB] FAIL b2b_order t=%0d: got pg=%b %h/%h want 1 %h/%h", t, pre_grant, ev_addr, w_data, mAddr, mData);
      end
      stepCycle();
    end
    reqProb = 0; reqBudget = 0;
    repeat (30) stepCycle();
    nCompared++;
    if (fifo_count !== 5'd0) begin nMismatched++; $display("[TB] FAIL b2b_empty: got %0d want 0", fifo_count); end
  endtask

  task automatic test_layer_end();
    int nPre, pulses, firstAt, secondAt, preAtDone;
    logic [31:0] spikeAtDone;
    reqProb = 100; reqBudget = 3; readyProb = 0;
    repeat (8) stepCycle();
    nCompared++;
    if (fifo_count !== 5'd3) begin nMismatched++; $display("[TB] FAIL layer_fill: got %0d want 3", fifo_count); end
    for (int f = 0; f < N; f++) begin
      finVec = '0; finVec[f] = 1'b1;
      driveInputs();
      stepCycle();
      nCompared++;
      if (layer_done !== 1'b0) begin nMismatched++; $display("[TB] FAIL layer_early f=%0d: got 1 want 0", f); end
    end
    repeat (2) stepCycle();
    readyProb = 100; preReadyVar = 1'b1;
    driveInputs();
    nPre = 0; pulses = 0; firstAt = -1; secondAt = -1; preAtDone = -1; spikeAtDone = 32'hFFFF_FFFF;
    for (int t = 0; t < 12; t++) begin
      stepCycle();
      nCompared++;
      if (layer_done !== mLayerDone) begin nMismatched++; $display("[TB] FAIL layer_model t=%0d: got %b want %b", t, layer_done, mLayerDone); end
      if (pre_grant) nPre++;
      if (layer_done) begin
        pulses++;
        if (pulses == 1) begin
          firstAt = t; preAtDone = nPre; spikeAtDone = spike_cnt;
          finVec = '1;
          driveInputs();
        end else secondAt = t;
      end
    end
    nCompared++;
    if (preAtDone != 3 || spikeAtDone !== 32'd0) begin
      nMismatched++; $display("[TB] FAIL layer_done: got pre_grants=%0d spike_cnt=%0d want 3/0", preAtDone, spikeAtDone);
    end
    nCompared++;
    if (pulses != 2 || secondAt - firstAt != 2) begin
      nMismatched++; $display("[TB] FAIL layer_next: got pulses=%0d gap=%0d want 2/2", pulses, secondAt - firstAt);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    readyProb = 0; preReadyVar = 1'b0; reqProb = 100; reqBudget = -1;
    driveInputs();
    found = 1'b0;
    for (int t = 0; t < 30 && !found; t++) begin
      stepCycle();
      if (q.size() == 5 && mGrant != '0) found = 1'b1;
    end
    nCompared++;
    if (!found || fifo_count !== 5'd5 || post_grant == '0) begin
      nMismatched++; $display("[TB] FAIL rstmid_setup: got cnt=%0d grant=%b want 5 with a grant", fifo_count, post_grant);
    end
    #2 rst = 1'b0;
    #1;
    nCompared++;
    if ({post_grant, pre_grant, w_data, ev_addr, fifo_count, spike_cnt, layer_done} !== '0) begin
      nMismatched++; $display("[TB] FAIL rstmid_outputs: got grant=%b pg=%b cnt=%0d sc=%0d want all 0", post_grant, pre_grant, fifo_count, spike_cnt);
    end
    applyReset();
    readyProb = 100; preReadyVar = 1'b1;
    driveInputs();
    for (int t = 0; t < 10; t++) begin
      stepCycle();
      nCompared++;
      if (pre_grant !== 1'b0 || fifo_count !== 5'd0 || post_grant !== '0) begin
        nMismatched++; $display("[TB] FAIL rstmid_after t=%0d: got pg=%b cnt=%0d grant=%b want 0/0/0", t, pre_grant, fifo_count, post_grant);
      end
    end
  endtask

  task automatic test_random();
    applyReset();
    for (int r = 0; r < 8; r++) begin
      for (int t = 0; t < 100; t++) begin
        reqBudget = -1;
        reqProb   = (t < 80) ? 50 : 0;
        readyProb = (t < 80) ? 60 : 100;
        if ($urandom_range(9) == 0) finVec = N'($urandom);
        driveInputs();
        stepCycle();
        nCompared++;
        if (post_grant !== mGrant) begin nMismatched++; $display("[TB] FAIL rand_grant r=%0d t=%0d: got %b want %b", r, t, post_grant, mGrant); end
        nCompared++;
        if (pre_grant !== mPreGrant) begin nMismatched++; $display("[TB] FAIL rand_pre_grant r=%0d t=%0d: got %b want %b", r, t, pre_grant, mPreGrant); end
        nCompared++;
        if (ev_addr !== mAddr || w_data !== mData) begin
          nMismatched++; $display("[TB] FAIL rand_event r=%0d t=%0d: got %h/%h want %h/%h", r, t, ev_addr, w_data, mAddr, mData);
        end
        nCompared++;
        if (fifo_count !== 5'(q.size())) begin nMismatched++; $display("[TB] FAIL rand_count r=%0d t=%0d: got %0d want %0d", r, t, fifo_count, q.size()); end
        nCompared++;
        if (spike_cnt !== mSpike) begin nMismatched++; $display("[TB] FAIL rand_spike r=%0d t=%0d: got %0d want %0d", r, t, spike_cnt, mSpike); end
        nCompared++;
        if (layer_done !== mLayerDone) begin nMismatched++; $display("[TB] FAIL rand_layer r=%0d t=%0d: got %b want %b", r, t, layer_done, mLayerDone); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_full();
    test_back_to_back();
    test_layer_end();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/spike_collector.md
# spike_collector

Receiving end of the cluster spike-output interface. It round-robin arbitrates the `post_req`/`post_waddr`/`post_wdata` requests from up to `CLUSTER_NUM` clusters and issues `post_grant` pulses. Accepted spike events are buffered in an internal FIFO, then replayed to the next layer's workload managers as `pre_grant`/`w_data` input events. It also detects end of layer: all schedulers finished and the buffer fully drained.

## Interface
Parameters:
- `CLUSTER_NUM`, 4, number of requesting clusters.
- `POST_WIDTH`, 32, width of spike address and data words.
- `DEPTH`, 16, event FIFO depth (power of two, ≥4).

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `post_req` in `CLUSTER_NUM`: per-cluster spike request. The cluster holds it, with address and data stable, until granted.
- `post_waddr` in `CLUSTER_NUM*POST_WIDTH`: packed addresses; cluster i occupies bits [i*POST_WIDTH +: POST_WIDTH].
- `post_wdata` in `CLUSTER_NUM*POST_WIDTH`: packed spike data, same packing as `post_waddr`.
- `post_grant` out `CLUSTER_NUM`: one-hot, single-cycle grant.
- `finish_sche` in `CLUSTER_NUM`: per-cluster scheduler-done pulse.
- `pre_ready` in 1: downstream can accept an event this cycle.
- `pre_grant` out 1: event-valid pulse to downstream.
- `w_data` out `POST_WIDTH`: event data, valid while `pre_grant`=1.
- `ev_addr` out `POST_WIDTH`: event address, valid while `pre_grant`=1.
- `fifo_count` out `$clog2(DEPTH)+1`: current occupancy.
- `spike_cnt` out 32: events accepted in the current layer.
- `layer_done` out 1: single-cycle end-of-layer pulse.

## Operation
- Reset: `post_grant`=0, `pre_grant`=0, `w_data`=0, `ev_addr`=0, `fifo_count`=0, `spike_cnt`=0, `layer_done`=0. FIFO pointers 0, round-robin pointer 0, finish sticky bits 0.
- Reset is honoured mid-operation: the FIFO is discarded and any in-flight grant is dropped.
- Arbitration:
  - Eligible set = `post_req & ~post_grant`. Masking the cluster granted in the current cycle prevents a double grant while its request is still falling.
  - Round-robin search starts at `rr_ptr`. On a grant to cluster i, `rr_ptr` becomes (i+1) mod `CLUSTER_NUM`.
  - A grant is issued only if `fifo_count` + (1 if a push is already in flight) < `DEPTH`.
  - No eligible request, or space check fails → `post_grant`=0 and `rr_ptr` unchanged.
- Capture: in the cycle where `post_grant[i]`=1, the FIFO pushes {`post_waddr[i]`, `post_wdata[i]`} at the closing edge, and `spike_cnt` increments.
- Drain: if the FIFO is non-empty and `pre_ready`=1 at an edge, the head is popped, `pre_grant`=1 the next cycle, and `w_data`/`ev_addr` hold the head entry. Otherwise `pre_grant`=0 and `w_data`/`ev_addr` hold their last values.
- Simultaneous push and pop in one edge leaves `fifo_count` unchanged. Pointers wrap modulo `DEPTH`.
- End-of-layer tracking:
  - Each `finish_sche[i]` pulse sets sticky bit i.
  - When all sticky bits are 1, `fifo_count`=0, `post_req`=0, `post_grant`=0 and `pre_grant`=0, then `layer_done` pulses for one cycle.
  - On the same edge as that pulse, the sticky bits and `spike_cnt` clear.
  - A `finish_sche` arriving in the same cycle as `layer_done` belongs to the next layer and is kept.
- `spike_cnt` saturates at 2^32-1.

## Timing
- Request to grant: `post_req[i]` high at edge E with the cluster eligible and winning → `post_grant[i]` high during cycle E+1.
- Data is sampled at edge E+2. The requester must drop `post_req` no later than the cycle after it sees the grant.
- Throughput:
  - Different clusters can be granted in back-to-back cycles.
  - The same cluster is granted at most every other cycle.
- Drain latency: head available and `pre_ready` at edge E → `pre_grant` during cycle E+1. Sustained rate is 1 event/cycle.
- Pushed event to earliest `pre_grant`: 2 cycles (push edge, then pop edge).
- `layer_done` asserts one cycle after the last qualifying condition becomes true at an edge.

## Test plan
- Single request: cluster 2 raises `post_req` with waddr=0x10, wdata=0x5 and holds `pre_ready`=1. Expect `post_grant`=4'b0100 for one cycle. Two cycles later expect `pre_grant`=1, `ev_addr`=0x10, `w_data`=0x5, and `spike_cnt`=1.
- Fairness: all four clusters request continuously, re-raising after each grant. Expect grant order 0,1,2,3,0,…; over 40 cycles each cluster receives an equal count ±1.
- Full: `pre_ready`=0 with clusters requesting. Expect exactly 16 grants, `fifo_count`=16 and no further grant. Raising `pre_ready` for one cycle lets exactly one new grant follow.
- Simultaneous push/pop: keep occupancy at 8 with one grant and one drain per cycle. Expect `fifo_count` stable at 8 and events delivered in FIFO order.
- Layer end: pulse `finish_sche` 0–3 while 3 events are still buffered. Expect `layer_done` only after the third `pre_grant`, then `spike_cnt`=0.
- Reset mid-operation: deassert `rst` with 5 events buffered and a grant pending. Expect all outputs 0 immediately, and no `pre_grant` after reset is released.
